// File: rtl/aes_inv_core_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_core_iter -- iterative AES-128 decryption engine.
//
// Runs one inverse round per clock (InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns) while walking the key schedule backwards on the fly, starting
// from the round-10 key supplied by the host. No key storage is needed; the
// cipher key falls out of the last backward step and is returned on kout.
//
// Ports:
//   CLK         clock, rising edge
//   RSTn        asynchronous active-low reset
//   din_valid   ciphertext/key offer
//   din_ready   engine idle and able to accept (IDLE only)
//   din[127:0]  ciphertext, byte 0 = din[127:120], column-major
//   kin[127:0]  round-10 round key, same byte order
//   dout_valid  plaintext available (DONE)
//   dout_ready  consumer accepts dout
//   dout[127:0] plaintext (held after the handshake)
//   kout[127:0] recovered cipher (round-0) key
//   busy        high while rounds are running
//
// The file also holds the shared GF(2^8) helpers and the 8/32-bit leaves.
// S-boxes are built from the field inverse plus affine map rather than
// from 256-entry tables.
// ---------------------------------------------------------------------------

package aes_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0,
    // which is exactly what the S-box definition wants.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = a;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] v;
        v = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return gf_inv(v);
    endfunction

endpackage

// Forward S-box, used only by the key schedule's SubWord.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = aes_inv_pkg::sbox_fwd(a_i);
endmodule

module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = aes_inv_pkg::sbox_inv(a_i);
endmodule

// 32-bit forward SubBytes leaf (SubWord in the key schedule).
module aes_subbytes (
    input  logic [31:0] a_i,
    output logic [31:0] y_o
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_sbox u_sbox (.a_i(a_i[8*b +: 8]), .y_o(y_o[8*b +: 8]));
    end
endmodule

// 32-bit InvSubBytes leaf.
module aes_inv_subbytes (
    input  logic [31:0] a_i,
    output logic [31:0] y_o
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_inv_sbox u_isbox (.a_i(a_i[8*b +: 8]), .y_o(y_o[8*b +: 8]));
    end
endmodule

// 32-bit InvMixColumns leaf; a_i[31:24] is row 0 of the column.
module aes_inv_mixcolumns (
    input  logic [31:0] a_i,
    output logic [31:0] y_o
);
    import aes_inv_pkg::gf_mul;
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = a_i;

    assign y_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign y_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign y_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign y_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
endmodule

module aes_inv_core_iter #(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din,
    input  logic [127:0] kin,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout,
    output logic [127:0] kout,
    output logic         busy
);

    localparam logic [3:0] RND_FIRST = 4'(NR - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] st_q,   st_d;
    logic [127:0] rk_q,   rk_d;
    logic [3:0]   rnd_q,  rnd_d;
    logic [127:0] dout_q, dout_d;
    logic [127:0] kout_q, kout_d;

    // ---------------- backward key step ----------------
    logic [7:0]   rcon;
    logic [31:0]  p0, p1, p2, p3, rot_p3, sw_p3;
    logic [127:0] rk_prev;

    // rcon(rnd+1): the round counter already points at the key we are
    // stepping back to, so round 9 undoes the rcon=36 expansion step.
    always_comb begin
        rcon = 8'h00;
        case (rnd_q)
            4'd9:    rcon = 8'h36;
            4'd8:    rcon = 8'h1b;
            4'd7:    rcon = 8'h80;
            4'd6:    rcon = 8'h40;
            4'd5:    rcon = 8'h20;
            4'd4:    rcon = 8'h10;
            4'd3:    rcon = 8'h08;
            4'd2:    rcon = 8'h04;
            4'd1:    rcon = 8'h02;
            4'd0:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    assign p3     = rk_q[31:0]  ^ rk_q[63:32];
    assign p2     = rk_q[63:32] ^ rk_q[95:64];
    assign p1     = rk_q[95:64] ^ rk_q[127:96];
    assign rot_p3 = {p3[23:0], p3[31:24]};

    aes_subbytes u_subword (.a_i(rot_p3), .y_o(sw_p3));

    // Earlier key's w3 is recovered first, so SubWord sees the right input.
    assign p0      = rk_q[127:96] ^ sw_p3 ^ {rcon, 24'h0};
    assign rk_prev = {p0, p1, p2, p3};

    // ---------------- inverse round datapath ----------------
    logic [127:0] ark_w;   // after AddRoundKey (final-round result)
    logic [127:0] mc_w;    // after InvMixColumns (middle rounds)

    for (genvar c = 0; c < 4; c++) begin : g_col
        // Row r of output column c comes from input column (c - r) mod 4.
        localparam int J1 = (c + 3) % 4;
        localparam int J2 = (c + 2) % 4;
        localparam int J3 = (c + 1) % 4;

        logic [31:0] sr_col, sb_col, ark_col, mc_col;

        assign sr_col = {st_q[127 - 32*c       -: 8],
                         st_q[127 - 32*J1 - 8  -: 8],
                         st_q[127 - 32*J2 - 16 -: 8],
                         st_q[127 - 32*J3 - 24 -: 8]};

        aes_inv_subbytes u_isub (.a_i(sr_col), .y_o(sb_col));

        assign ark_col = sb_col ^ rk_prev[127 - 32*c -: 32];

        aes_inv_mixcolumns u_imix (.a_i(ark_col), .y_o(mc_col));

        assign ark_w[127 - 32*c -: 32] = ark_col;
        assign mc_w[127 - 32*c -: 32]  = mc_col;
    end

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        kout_d  = kout_q;

        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    // Round-10 AddRoundKey happens on acceptance.
                    st_d    = din ^ kin;
                    rk_d    = kin;
                    rnd_d   = RND_FIRST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rk_d  = rk_prev;
                rnd_d = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
                if (rnd_q == 4'd0) begin
                    st_d    = ark_w;
                    dout_d  = ark_w;
                    kout_d  = rk_prev;
                    state_d = S_DONE;
                end else begin
                    st_d = mc_w;
                end
            end
            S_DONE: begin
                if (dout_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            dout_q  <= '0;
            kout_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
            kout_q  <= kout_d;
        end
    end

    // Handshake/status outputs are pure state decodes; data outputs come
    // from dedicated registers so they survive the next acceptance.
    assign din_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign dout_valid = (state_q == S_DONE);
    assign dout       = dout_q;
    assign kout       = kout_q;

endmodule

// File: tb/tb_aes_inv_core_iter.sv
// Directed bench for aes_inv_core_iter: FIPS-197 vectors from a table, plus
// hand-written sequences for backpressure, ignored input, reset abort and
// back-to-back operation.
module tb_aes_inv_core_iter;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] din = '0;
    logic [127:0] kin = '0;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [127:0] dout;
    logic [127:0] kout;
    logic         busy;

    aes_inv_core_iter #(.NR(10)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .din_valid(din_valid), .din_ready(din_ready), .din(din), .kin(kin),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout(dout), .kout(kout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [127:0] ct;
        logic [127:0] key10;
        logic [127:0] pt;
        logic [127:0] key0;
    } vec_t;

    vec_t vecs[2];

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All driving and sampling happens 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [127:0] c, input logic [127:0] k);
        din       = c;
        kin       = k;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Counts edges after acceptance until dout_valid; run_ok clears if busy
    // or din_ready looks wrong in any RUN cycle. Bounded at 40 edges.
    task automatic wait_done(output int lat, output logic run_ok);
        lat    = 0;
        run_ok = 1'b1;
        while (!dout_valid && lat < 40) begin
            if (!busy || din_ready) run_ok = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic handshake();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input string tag);
        int   lat;
        logic ok;
        chk_b({tag, "/din_ready_pre"}, din_ready, 1'b1);
        start(vecs[idx].ct, vecs[idx].key10);
        wait_done(lat, ok);
        chk_i({tag, "/latency"}, lat, 10);
        chk_b({tag, "/run_flags"}, ok, 1'b1);
        chk_w({tag, "/dout"}, dout, vecs[idx].pt);
        chk_w({tag, "/kout"}, kout, vecs[idx].key0);
    endtask

    initial begin
        int   lat;
        logic ok;
        logic hold_ok;

        vecs[0] = '{"C1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                          128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{"A1", 128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                          128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c};

        // ---- reset state ----
        #3;
        chk_b("rst/din_ready", din_ready, 1'b1);
        chk_b("rst/dout_valid", dout_valid, 1'b0);
        chk_b("rst/busy", busy, 1'b0);
        chk_w("rst/dout", dout, '0);
        chk_w("rst/kout", kout, '0);
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
        step();

        // ---- table-driven vectors ----
        for (int i = 0; i < 2; i++) begin
            run_vec(i, vecs[i].name);
            chk_b({vecs[i].name, "/din_ready_done"}, din_ready, 1'b0);
            handshake();
            chk_b({vecs[i].name, "/valid_after_hs"}, dout_valid, 1'b0);
            chk_b({vecs[i].name, "/ready_after_hs"}, din_ready, 1'b1);
            chk_w({vecs[i].name, "/dout_kept"}, dout, vecs[i].pt);
        end

        // ---- backpressure ----
        run_vec(0, "bp");
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!dout_valid || din_ready || busy || dout !== vecs[0].pt || kout !== vecs[0].key0)
                hold_ok = 1'b0;
        end
        chk_b("bp/hold_20", hold_ok, 1'b1);
        handshake();
        chk_b("bp/ready_after_hs", din_ready, 1'b1);
        chk_b("bp/valid_after_hs", dout_valid, 1'b0);

        // ---- inputs toggled during RUN are ignored ----
        start(vecs[0].ct, vecs[0].key10);
        lat = 0;
        while (!dout_valid && lat < 40) begin
            din_valid = 1'b1;
            din = {$urandom(), $urandom(), $urandom(), $urandom()};
            kin = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            lat++;
        end
        din_valid = 1'b0;
        chk_i("ign/latency", lat, 10);
        chk_w("ign/dout", dout, vecs[0].pt);
        chk_w("ign/kout", kout, vecs[0].key0);
        handshake();
        step();
        step();
        chk_b("ign/no_second_block", busy, 1'b0);
        chk_b("ign/idle_ready", din_ready, 1'b1);

        // ---- reset abort at round 5 ----
        start(vecs[1].ct, vecs[1].key10);
        repeat (4) step();
        #2 RSTn = 1'b0;
        #1;
        chk_w("abort/dout", dout, '0);
        chk_w("abort/kout", kout, '0);
        chk_b("abort/din_ready", din_ready, 1'b1);
        chk_b("abort/busy", busy, 1'b0);
        chk_b("abort/dout_valid", dout_valid, 1'b0);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        step();
        run_vec(0, "abort_rerun");
        handshake();

        // ---- back-to-back with dout_ready tied high ----
        dout_ready = 1'b1;
        din        = vecs[0].ct;
        kin        = vecs[0].key10;
        din_valid  = 1'b1;
        step();
        wait_done(lat, ok);
        chk_i("b2b/first_latency", lat, 10);
        chk_w("b2b/first_dout", dout, vecs[0].pt);
        din = vecs[1].ct;
        kin = vecs[1].key10;
        step();                                   // handshake edge
        chk_b("b2b/not_taken_in_done", busy, 1'b0);
        chk_b("b2b/idle_after_hs", din_ready, 1'b1);
        step();                                   // acceptance edge
        chk_b("b2b/second_accepted", busy, 1'b1);
        din_valid = 1'b0;
        wait_done(lat, ok);
        chk_i("b2b/second_latency", lat, 10);
        chk_w("b2b/second_dout", dout, vecs[1].pt);
        chk_w("b2b/second_kout", kout, vecs[1].key0);
        step();
        dout_ready = 1'b0;
        chk_b("b2b/final_idle", din_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_inv_core_iter.md
Name: aes_inv_core_iter

Overview:
- Iterative AES-128 decryption engine. It is the inverse-cipher counterpart of the combinational encryption round core.
- One inverse round is executed per clock: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns.
- The round-key schedule is run backwards on the fly, starting from the last (round-10) round key. No key RAM or precomputation is needed.
- Sits beside the encryption datapath. The host supplies ciphertext plus the final round key, and receives plaintext plus the recovered cipher key.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; any other value is unsupported).

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- din_valid  input  1  ciphertext/key offer.
- din_ready  output  1  engine can accept; high only in IDLE.
- din  input  128  ciphertext; byte 0 = din[127:120], column-major as in the encryption core.
- kin  input  128  round-10 round key, same byte order.
- dout_valid  output  1  plaintext available.
- dout_ready  input  1  consumer accepts dout.
- dout  output  128  plaintext.
- kout  output  128  recovered round-0 key, i.e. the cipher key.
- busy  output  1  high while in RUN.

Behaviour:
- Clock and reset: one clock, CLK. RSTn is asynchronous, active-low. Reset takes effect immediately and clears all registers.
- Reset values:
  - state = IDLE.
  - din_ready = 1, dout_valid = 0, busy = 0.
  - dout = 0, kout = 0, round counter = 0.
- Datapath registers:
  - st[127:0], the state.
  - rk[127:0], the current round key.
  - rnd[3:0], the round counter.
- FSM transitions:
  - IDLE: on din_valid & din_ready at edge T: st <= din ^ kin, rk <= kin, rnd <= 9, go to RUN.
  - RUN: each edge computes rk_prev = invexp(rk, rcon(rnd+1)).
    - rnd != 0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_prev).
    - rnd == 0: the final round omits InvMixColumns: st <= InvSubBytes(InvShiftRows(st)) ^ rk_prev. Go to DONE.
    - Every RUN edge: rk <= rk_prev, rnd <= rnd - 1 (not decremented below 0).
  - DONE: dout = st, kout = rk, dout_valid = 1. Both outputs are held stable until dout_ready is sampled high; then go to IDLE.
- Latency: 10 RUN edges (T+1..T+10). dout_valid is high from just after edge T+10. Minimum 11 cycles from acceptance to result; throughput is one block per 12 cycles with dout_ready tied high.
- Inverse key expansion invexp: for input words w0..w3 (w0 = bits 127:96):
  - p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - RotWord rotates bytes left by one. SubWord uses the existing forward SubBytes leaf.
- rcon(i), for i = 10..1: 36, 1b, 80, 40, 20, 10, 08, 04, 02, 01 (hex).
- InvShiftRows: row r is rotated right by r bytes. Output columns:
  - c0 = {s0[31:24], s3[23:16], s2[15:8], s1[7:0]}.
  - c1, c2, c3 rotate the column indices cyclically.
- InvSubBytes and InvMixColumns are companion combinational 32-bit leaves with the same port shape as SubBytes/MixColumns. InvMixColumns uses coefficients {0e, 0b, 0d, 09}.
- Inputs during RUN/DONE: din and kin are ignored. din_ready = 0, so a din_valid pulse is neither lost nor latched.
- Simultaneous events: din_valid in DONE is not accepted until the cycle after the dout handshake (IDLE).
- dout_valid deasserts on the edge where dout_valid & dout_ready. dout and kout keep their last value afterwards.
- Reset mid-operation: an asynchronous RSTn low in RUN or DONE aborts. All registers go to reset values, no partial result is output, and the next block restarts cleanly.
- Registered outputs: all outputs are registered or decoded directly from the FSM state. There is no combinational path from din/kin to any output.

Test Plan:
- FIPS-197 C.1: din = 69c4e0d86a7b0430d8cdb78070b4c55a, kin = 13111d7fe3944a17f307a78b4d2b30c5 -> dout = 00112233445566778899aabbccddeeff and kout = 000102030405060708090a0b0c0d0e0f, dout_valid high exactly 10 edges after acceptance.
- FIPS-197 A.1/B: din = 3925841d02dc09fbdc118597196a0b32, kin = d014f9a8c9ee2589e13f0cc8b6630ca6 -> dout = 3243f6a8885a308d313198a2e0370734, kout = 2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: hold dout_ready = 0 for 20 cycles after done -> dout_valid and dout stay constant and din_ready stays 0; then pulse dout_ready -> IDLE next edge and din_ready = 1.
- Ignored input: toggle din/kin/din_valid during RUN -> result still equals the C.1 plaintext; no second block is started.
- Reset abort: assert RSTn low at RUN round 5 -> outputs immediately zero and din_ready = 1; then re-run C.1 -> correct result.
- Back-to-back: issue C.1 then A.1 with dout_ready = 1 -> both plaintexts correct, second accepted on the cycle after the first handshake.
